// File: rtl/ss_scroll_ctrl.sv
// ss_scroll_ctrl: per-frame camera scroll and map-segment selection.
// Optional feature macro: SS_SCROLL_FORCE_EN (adds force_en / force_map override of map_sel).
// Position is tracked as a tile column (LocX) plus a fine pixel offset (fine_x).
// A segment change blanks the picture for HOLD_FRAMES frames while the position is frozen.
`timescale 1ns/1ps

module ss_scroll_ctrl #(
    parameter int         TILE_PX     = 16,
    parameter int         SPEED       = 2,
    parameter int         MAP_COLS    = 128,
    parameter logic [7:0] SWITCH_COL  = 8'h7C,
    parameter int         HOLD_FRAMES = 4
) (
    input  logic                       clk_75,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       move_right,
    input  logic                       move_left,
    input  logic                       pause,
`ifdef SS_SCROLL_FORCE_EN
    input  logic                       force_en,
    input  logic [1:0]                 force_map,
`endif
    output logic [7:0]                 LocX,
    output logic [$clog2(TILE_PX)-1:0] fine_x,
    output logic [1:0]                 map_sel,
    output logic                       blank,
    output logic                       map_changed
);

    localparam int         FW        = $clog2(TILE_PX);
    localparam int         CW        = $clog2(HOLD_FRAMES + 1);
    localparam logic [FW:0] SPD      = (FW + 1)'(SPEED);
    localparam logic [FW:0] TPX      = (FW + 1)'(TILE_PX);
    localparam logic [7:0]  LAST_COL = 8'(MAP_COLS - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_LR      = 2'd0,
        S_FADE_P1 = 2'd1,
        S_PART1   = 2'd2,
        S_FADE_LR = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      loc_x_q, loc_x_d;
    logic [FW-1:0]   fine_x_q, fine_x_d;
    logic [CW-1:0]   fade_cnt_q, fade_cnt_d;
    logic [1:0]      map_sel_q, map_sel_d;
    logic            blank_q, blank_d;
    logic            map_changed_q, map_changed_d;

    logic [FW:0]     fine_ext;
    logic            carry, borrow, go_right, go_left, step, hold_fsm;
    logic [7:0]      loc_inc, floor_col;
    logic [1:0]      fsm_map;

    // Next-state computation: move decode, carry/borrow arithmetic, clamps and fade sequencing.
    always_comb begin
        state_d       = state_q;
        loc_x_d       = loc_x_q;
        fine_x_d      = fine_x_q;
        fade_cnt_d    = fade_cnt_q;
        fine_ext      = {1'b0, fine_x_q};
        carry         = (fine_ext + SPD) >= TPX;
        borrow        = fine_ext < SPD;
        loc_inc       = (loc_x_q == LAST_COL) ? 8'd0 : loc_x_q + 8'd1;
        floor_col     = (state_q == S_PART1) ? SWITCH_COL : 8'd0;
        go_right      = move_right & ~move_left;
        go_left       = move_left & ~move_right;
        step          = frame_tick & ~pause;
`ifdef SS_SCROLL_FORCE_EN
        hold_fsm      = force_en;
`else
        hold_fsm      = 1'b0;
`endif

        case (state_q)
            S_LR, S_PART1: begin
                if (step && go_right) begin
                    if (carry) begin
                        fine_x_d = FW'(fine_ext + SPD - TPX);
                        loc_x_d  = loc_inc;
                        if (!hold_fsm && state_q == S_LR && loc_inc == SWITCH_COL) begin
                            state_d = S_FADE_P1;
                        end else if (!hold_fsm && state_q == S_PART1 && loc_x_q == LAST_COL) begin
                            state_d = S_FADE_LR;
                        end
                    end else begin
                        fine_x_d = FW'(fine_ext + SPD);
                    end
                end else if (step && go_left) begin
                    if (borrow) begin
                        if (loc_x_q == floor_col) begin
                            fine_x_d = '0;
                        end else begin
                            fine_x_d = FW'(fine_ext + TPX - SPD);
                            loc_x_d  = loc_x_q - 8'd1;
                        end
                    end else begin
                        fine_x_d = FW'(fine_ext - SPD);
                    end
                end
            end
            S_FADE_P1, S_FADE_LR: begin
                if (step && !hold_fsm) begin
                    if (fade_cnt_q == HOLD_LAST) begin
                        fade_cnt_d = '0;
                        state_d    = (state_q == S_FADE_P1) ? S_PART1 : S_LR;
                    end else begin
                        fade_cnt_d = fade_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_LR;
            end
        endcase

        fsm_map       = (state_d == S_FADE_P1 || state_d == S_PART1) ? 2'd2 : 2'd0;
        blank_d       = (state_d == S_FADE_P1 || state_d == S_FADE_LR);
        map_changed_d = (state_q == S_LR && state_d == S_FADE_P1) ||
                        (state_q == S_PART1 && state_d == S_FADE_LR);
`ifdef SS_SCROLL_FORCE_EN
        map_sel_d     = force_en ? force_map : fsm_map;
`else
        map_sel_d     = fsm_map;
`endif
    end

    // State and registered outputs; asynchronous active-low reset clears everything.
    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            state_q       <= S_LR;
            loc_x_q       <= 8'd0;
            fine_x_q      <= '0;
            fade_cnt_q    <= '0;
            map_sel_q     <= 2'd0;
            blank_q       <= 1'b0;
            map_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            loc_x_q       <= loc_x_d;
            fine_x_q      <= fine_x_d;
            fade_cnt_q    <= fade_cnt_d;
            map_sel_q     <= map_sel_d;
            blank_q       <= blank_d;
            map_changed_q <= map_changed_d;
        end
    end

    assign LocX        = loc_x_q;
    assign fine_x      = fine_x_q;
    assign map_sel     = map_sel_q;
    assign blank       = blank_q;
    assign map_changed = map_changed_q;

endmodule

// File: tb/tb_ss_scroll_ctrl.sv
// Testbench for ss_scroll_ctrl (default build, SS_SCROLL_FORCE_EN undefined).
// A pixel-position model predicts every output each cycle; literal checks pin key points.
`timescale 1ns/1ps

module tb_ss_scroll_ctrl;

    localparam int TILE_PX     = 16;
    localparam int SPEED       = 2;
    localparam int MAP_COLS    = 128;
    localparam int SWITCH_COL  = 8'h7C;
    localparam int HOLD_FRAMES = 4;

    logic       clk_75;
    logic       reset;
    logic       frame_tick;
    logic       move_right;
    logic       move_left;
    logic       pause;
    logic [7:0] LocX;
    logic [3:0] fine_x;
    logic [1:0] map_sel;
    logic       blank;
    logic       map_changed;

    int vec_count  = 0;
    int miss_count = 0;
    bit check_en   = 0;

    // Model state: absolute pixel position, current segment, remaining blank frames.
    int pos        = 0;
    bit in_part1   = 0;
    int fade_left  = 0;
    bit exp_change = 0;

    ss_scroll_ctrl dut (
        .clk_75     (clk_75),
        .reset      (reset),
        .frame_tick (frame_tick),
        .move_right (move_right),
        .move_left  (move_left),
        .pause      (pause),
        .LocX       (LocX),
        .fine_x     (fine_x),
        .map_sel    (map_sel),
        .blank      (blank),
        .map_changed(map_changed)
    );

    initial clk_75 = 1'b0;
    always #5 clk_75 = ~clk_75;

    // Behavioural model: position in pixels with floors per segment and a blanking countdown.
    always @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            pos        = 0;
            in_part1   = 0;
            fade_left  = 0;
            exp_change = 0;
        end else begin
            exp_change = 0;
            if (frame_tick && !pause) begin
                if (fade_left > 0) begin
                    fade_left = fade_left - 1;
                end else if (move_right && !move_left) begin
                    pos = pos + SPEED;
                    if (!in_part1 && pos >= SWITCH_COL * TILE_PX) begin
                        in_part1   = 1;
                        fade_left  = HOLD_FRAMES;
                        exp_change = 1;
                    end else if (in_part1 && pos >= MAP_COLS * TILE_PX) begin
                        pos        = pos - MAP_COLS * TILE_PX;
                        in_part1   = 0;
                        fade_left  = HOLD_FRAMES;
                        exp_change = 1;
                    end
                end else if (move_left && !move_right) begin
                    pos = pos - SPEED;
                    if (in_part1 && pos < SWITCH_COL * TILE_PX) pos = SWITCH_COL * TILE_PX;
                    if (!in_part1 && pos < 0) pos = 0;
                end
            end
        end
    end

    // Every-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk_75) begin
        if (check_en) begin
            vec_count = vec_count + 1;
            if (LocX !== 8'(pos / TILE_PX) || fine_x !== 4'(pos % TILE_PX) ||
                map_sel !== (in_part1 ? 2'd2 : 2'd0) || blank !== (fade_left > 0) ||
                map_changed !== exp_change) begin
                miss_count = miss_count + 1;
                $display("[TB] FAIL model t=%0t got LocX=%h fine=%0d map=%0d blank=%b chg=%b want LocX=%h fine=%0d map=%0d blank=%b chg=%b",
                         $time, LocX, fine_x, map_sel, blank, map_changed,
                         pos / TILE_PX, pos % TILE_PX, in_part1 ? 2 : 0, fade_left > 0, exp_change);
            end
        end
    end

    // Issue n frame ticks (two cycles apart) with the given move/pause levels.
    task automatic applyStimulus(input bit r, input bit l, input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_75);
            move_right = r;
            move_left  = l;
            pause      = p;
            frame_tick = 1'b1;
            @(negedge clk_75);
            frame_tick = 1'b0;
        end
    endtask

    // Compare the outputs against hand-computed literal values.
    task automatic checkOutput(input string name, input logic [7:0] loc, input logic [3:0] fine,
                               input logic [1:0] map, input logic blk, input logic chg);
        vec_count = vec_count + 1;
        if (LocX !== loc || fine_x !== fine || map_sel !== map || blank !== blk || map_changed !== chg) begin
            miss_count = miss_count + 1;
            $display("[TB] FAIL %s got LocX=%h fine=%0d map=%0d blank=%b chg=%b want LocX=%h fine=%0d map=%0d blank=%b chg=%b",
                     name, LocX, fine_x, map_sel, blank, map_changed, loc, fine, map, blk, chg);
        end
    endtask

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        move_right = 1'b0;
        move_left  = 1'b0;
        pause      = 1'b0;
        repeat (3) @(negedge clk_75);
        checkOutput("reset_state", 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);
        check_en = 1;
        reset    = 1'b1;
        $display("[TB] reset released");

        applyStimulus(1, 0, 0, 8);
        checkOutput("right8", 8'h01, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("right9", 8'h01, 4'd2, 2'd0, 1'b0, 1'b0);

        applyStimulus(0, 1, 0, 9);
        checkOutput("left_to_zero", 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("lr_left_clamp", 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 2);
        checkOutput("both_no_move", 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);

        applyStimulus(1, 0, 0, 991);
        checkOutput("before_switch", 8'h7B, 4'd14, 2'd0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("switch_to_p1", 8'h7C, 4'd0, 2'd2, 1'b1, 1'b1);
        @(negedge clk_75);
        checkOutput("changed_one_cycle", 8'h7C, 4'd0, 2'd2, 1'b1, 1'b0);

        applyStimulus(1, 0, 0, 2);
        applyStimulus(1, 1, 1, 3);
        checkOutput("fade_paused", 8'h7C, 4'd0, 2'd2, 1'b1, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("fade_third", 8'h7C, 4'd0, 2'd2, 1'b1, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("fade_p1_done", 8'h7C, 4'd0, 2'd2, 1'b0, 1'b0);

        applyStimulus(0, 1, 0, 1);
        checkOutput("p1_left_clamp", 8'h7C, 4'd0, 2'd2, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 31);
        checkOutput("p1_last_col", 8'h7F, 4'd14, 2'd2, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("wrap_to_lr", 8'h00, 4'd0, 2'd0, 1'b1, 1'b1);
        applyStimulus(1, 0, 0, 3);
        checkOutput("fade_lr_frozen", 8'h00, 4'd0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("fade_lr_done", 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);

        applyStimulus(1, 0, 0, 992);
        checkOutput("switch_again", 8'h7C, 4'd0, 2'd2, 1'b1, 1'b1);
        applyStimulus(1, 0, 0, 2);
        @(negedge clk_75);
        #2 reset = 1'b0;
        #1 checkOutput("async_reset_mid_fade", 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk_75);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 3);
        checkOutput("scroll_after_reset", 8'h00, 4'd6, 2'd0, 1'b0, 1'b0);

        @(negedge clk_75);
        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/ss_scroll_ctrl.md
Name: ss_scroll_ctrl

Overview:
Camera/scroll controller directly upstream of the sidescroller map muxer.
- Once per video frame, converts player move requests into a tile-column scroll position (LocX) and a fine pixel offset.
- Owns the world-map segment selection (map_sel) as a clean synchronous FSM, with a short blanking hold on every segment change.
- map_sel and LocX feed the muxer and the video address generator.

Parameters:
TILE_PX, 16, pixels per tile column; power of 2; fine_x width = log2(TILE_PX)
SPEED, 2, pixels advanced per frame_tick; must satisfy 1 <= SPEED < TILE_PX
MAP_COLS, 128, tile columns per segment; LocX range 0..MAP_COLS-1
SWITCH_COL, 8'h7C, column at which the LR segment hands over to PART1
HOLD_FRAMES, 4, frame_ticks of blanking on a segment change; must be >= 1

Ports:
clk_75  input  1  75 MHz pixel-domain clock
reset  input  1  asynchronous, active-low
frame_tick  input  1  one-cycle pulse per frame (vsync start)
move_right  input  1  level, sampled on frame_tick
move_left  input  1  level, sampled on frame_tick
pause  input  1  level; freezes scroll and fade counter
LocX  output  8  current tile column
fine_x  output  log2(TILE_PX)  pixel offset within column
map_sel  output  2  0 = LR segment, 2 = PART1 segment
blank  output  1  high during segment-change hold
map_changed  output  1  one-cycle pulse when map_sel changes

Behaviour:
- Reset (reset = 0, asynchronous):
  - LocX = 0, fine_x = 0, map_sel = 0, blank = 0, map_changed = 0.
  - State = S_LR; fade counter = 0.
  - Reset is effective mid-fade or mid-move; no partial update survives.
- All outputs are registered. An update occurs on the clk_75 edge where frame_tick = 1; outputs are visible one cycle later.
- Move decode, on a tick with pause = 0:
  - right only: +SPEED.
  - left only: -SPEED.
  - both or neither: no move.
- Right arithmetic:
  - If fine_x + SPEED >= TILE_PX: fine_x = fine_x + SPEED - TILE_PX and LocX = LocX + 1.
  - Otherwise: fine_x = fine_x + SPEED.
- Left arithmetic:
  - If fine_x < SPEED: borrow, fine_x = fine_x + TILE_PX - SPEED and LocX = LocX - 1.
  - Otherwise: fine_x = fine_x - SPEED.
- S_LR:
  - Left clamp: if LocX = 0 and fine_x < SPEED, fine_x = 0 and LocX stays 0.
  - When a right carry makes LocX = SWITCH_COL:
    - Next state = S_FADE_P1.
    - map_sel = 2, blank = 1, map_changed = 1, all in the same update as the LocX change.
- S_PART1:
  - Left clamp: if LocX = SWITCH_COL and fine_x < SPEED, fine_x = 0 and LocX stays SWITCH_COL.
  - When a right carry occurs at LocX = MAP_COLS-1:
    - LocX wraps to 0.
    - Next state = S_FADE_LR.
    - map_sel = 0, blank = 1, map_changed = 1.
- S_FADE_P1 / S_FADE_LR:
  - Moves are ignored and LocX/fine_x are frozen.
  - Each unpaused frame_tick increments the fade counter.
  - On the HOLD_FRAMES-th counted tick: counter clears, blank = 0, and the state becomes S_PART1 or S_LR respectively.
- map_changed is high for exactly one clk_75 cycle per segment change. It is never asserted in S_LR or S_PART1 steady state.
- pause = 1 on a tick: no state, counter or position change.
- A frame_tick held high for multiple cycles counts once per cycle. Upstream guarantees single-cycle pulses; the bench checks the DUT against that contract only.

Optional Feature:
SS_SCROLL_FORCE_EN. When defined, adds these inputs:
- force_en (1 bit)
- force_map (2 bits)

Behaviour with the macro defined, while force_en = 1:
- map_sel = force_map combinationally registered (1-cycle latency).
- The FSM is held in its current state and no fades start.
- Scroll arithmetic and clamps still run per the current state.
- On force_en falling, map_sel returns to the FSM's value on the next cycle, with no map_changed pulse.

Without the macro: the ports are absent and map_sel is FSM-driven only.

Test Plan:
- Reset, then 8 ticks with move_right = 1 -> LocX = 1, fine_x = 0; 1 further tick -> fine_x = 2.
- From LocX = 0, fine_x = 1, one move_left tick -> fine_x = 0, LocX = 0 (clamp); map_sel stays 0.
- Drive right until the carry into LocX = 0x7C -> same update gives map_sel = 2, blank = 1, and a 1-cycle map_changed; 4 further ticks with move_right held -> LocX = 0x7C, fine_x = 0 (frozen); blank falls after the 4th tick.
- In S_PART1 at LocX = 0x7F, fine_x = 14, one right tick -> LocX = 0, fine_x = 0, map_sel = 0, blank = 1.
- move_left and move_right both 1, plus ticks with pause = 1 during a fade -> no position change and fade counter unchanged; release pause -> fade completes after the remaining ticks.
- Assert reset mid-fade (counter = 2) -> all outputs return to reset values asynchronously; after release, normal scroll from LocX = 0.
